// File: rtl/pi_controller.sv
// Two-stage fixed-point PI regulator with saturated output and valid pulse.
// Optional anti-windup hold is enabled by defining PI_ANTI_WINDUP_EN.
module pi_controller #(
  parameter int WIDTH           = 10,
  parameter int FRACTIONAL_BITS = 8,
  parameter int ACC_WIDTH       = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] setpoint,
  input  logic signed [WIDTH-1:0] feedback,
  input  logic signed [WIDTH-1:0] kp,
  input  logic signed [WIDTH-1:0] ki,
  input  logic signed [WIDTH-1:0] out_min,
  input  logic signed [WIDTH-1:0] out_max,
  input  logic                    integ_clr,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] u_out,
  output logic                    saturated
);

  localparam int PW = 2*WIDTH + 1;
  // Wide enough for integ + ki*e and for p + i_cand without overflow.
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 2;
  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic signed [WIDTH:0]     e_q, e_d;
  logic                      v1_q, v1_d;
  logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]   u_out_q, u_out_d;
  logic                      sat_q, sat_d;

  logic signed [PW-1:0] kp_x, ki_x, e_x, p, ki_e;
  logic signed [SW-1:0] p_w, kie_w, integ_w, i_sum, i_cand_w, sum_w, raw;
  logic signed [SW-1:0] omax_w, omin_w;
  logic                 e_pos, e_neg, over, under, hold;

  always_comb begin
    v1_d = in_valid;
    e_d  = e_q;
    if (in_valid) begin
      e_d = {setpoint[WIDTH-1], setpoint} - {feedback[WIDTH-1], feedback};
    end
  end

  always_comb begin
    kp_x    = {{(PW-WIDTH){kp[WIDTH-1]}}, kp};
    ki_x    = {{(PW-WIDTH){ki[WIDTH-1]}}, ki};
    e_x     = {{(PW-WIDTH-1){e_q[WIDTH]}}, e_q};
    p       = kp_x * e_x;
    ki_e    = ki_x * e_x;
    p_w     = {{(SW-PW){p[PW-1]}}, p};
    kie_w   = {{(SW-PW){ki_e[PW-1]}}, ki_e};
    integ_w = {{(SW-ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q};
    i_sum   = integ_w + kie_w;

    if (integ_clr) begin
      i_cand_w = '0;
    end else if (i_sum > ACC_MAX) begin
      i_cand_w = ACC_MAX;
    end else if (i_sum < ACC_MIN) begin
      i_cand_w = ACC_MIN;
    end else begin
      i_cand_w = i_sum;
    end

    sum_w  = p_w + i_cand_w;
    raw    = sum_w >>> FRACTIONAL_BITS;
    omax_w = {{(SW-WIDTH){out_max[WIDTH-1]}}, out_max};
    omin_w = {{(SW-WIDTH){out_min[WIDTH-1]}}, out_min};
    over   = raw > omax_w;
    under  = raw < omin_w;
    e_neg  = e_q[WIDTH];
    e_pos  = !e_q[WIDTH] && (e_q != '0);
`ifdef PI_ANTI_WINDUP_EN
    hold = (over && e_pos) || (under && e_neg);
`else
    hold = 1'b0;
`endif
  end

  always_comb begin
    out_valid_d = v1_q;
    u_out_d     = u_out_q;
    sat_d       = sat_q;
    integ_d     = integ_q;
    if (v1_q) begin
      // Upper clamp wins so inverted limits still give a defined result.
      if (over) begin
        u_out_d = out_max;
        sat_d   = 1'b1;
      end else if (under) begin
        u_out_d = out_min;
        sat_d   = 1'b1;
      end else begin
        u_out_d = raw[WIDTH-1:0];
        sat_d   = 1'b0;
      end
      if (!hold) begin
        integ_d = i_cand_w[ACC_WIDTH-1:0];
      end
    end
    if (integ_clr) begin
      integ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q         <= '0;
      v1_q        <= 1'b0;
      integ_q     <= '0;
      out_valid_q <= 1'b0;
      u_out_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      e_q         <= e_d;
      v1_q        <= v1_d;
      integ_q     <= integ_d;
      out_valid_q <= out_valid_d;
      u_out_q     <= u_out_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign u_out     = u_out_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_pi_controller.sv
// Scoreboard bench for pi_controller: default instance plus a 16-bit
// integrator instance, both checked against an arithmetic reference model.
module tb_pi_controller;

  typedef struct {
    longint u;
    bit     s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [9:0] setpoint = '0, feedback = '0;
  logic signed [9:0] kp = 10'sd256, ki = 10'sd128, ki16 = 10'sd511;
  logic signed [9:0] out_min = -10'sd200, out_max = 10'sd200;
  logic integ_clr = 1'b0;
  logic out_valid, saturated, out_valid16, saturated16;
  logic signed [9:0] u_out, u_out16;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t q16[$];
  longint integ_m = 0, integ16_m = 0;
  bit clr_pipe = 1'b0;
  longint last_u = 0, last_u16 = 0;
  bit last_s = 1'b0, last_s16 = 1'b0;
  bit r_smp;

  always #5 clk = ~clk;

  pi_controller dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki), .out_min(out_min), .out_max(out_max), .integ_clr(integ_clr),
    .out_valid(out_valid), .u_out(u_out), .saturated(saturated)
  );

  pi_controller #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki16), .out_min(out_min), .out_max(out_max), .integ_clr(integ_clr),
    .out_valid(out_valid16), .u_out(u_out16), .saturated(saturated16)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: PI law with integrator clamp, output clamp and optional hold.
  function automatic void model(input longint e, input longint k_p, input longint k_i,
                                input longint lo, input longint hi, input int accw,
                                input bit clr, inout longint integ, output exp_t ex);
    longint amax, amin, icand, raw;
    bit aw, hold;
`ifdef PI_ANTI_WINDUP_EN
    aw = 1'b1;
`else
    aw = 1'b0;
`endif
    amax  = (longint'(1) << (accw - 1)) - 1;
    amin  = -(longint'(1) << (accw - 1));
    icand = clr ? 0 : integ + k_i * e;
    if (icand > amax) icand = amax;
    if (icand < amin) icand = amin;
    raw = (k_p * e + icand) >>> 8;
    if (raw > hi) begin
      ex.u = hi; ex.s = 1'b1;
    end else if (raw < lo) begin
      ex.u = lo; ex.s = 1'b1;
    end else begin
      ex.u = raw; ex.s = 1'b0;
    end
    hold  = aw && ((raw > hi && e > 0) || (raw < lo && e < 0));
    integ = clr ? 0 : (hold ? integ : icand);
  endfunction

  task automatic cycle(input bit v, input int sp, input int fb, input bit clr);
    exp_t ex;
    @(negedge clk);
    integ_clr = clr_pipe;
    clr_pipe  = v & clr;
    in_valid  = v;
    setpoint  = 10'(sp);
    feedback  = 10'(fb);
    if (v) begin
      model(longint'(sp - fb), kp, ki, out_min, out_max, 24, clr, integ_m, ex);
      q.push_back(ex);
      model(longint'(sp - fb), kp, ki16, out_min, out_max, 16, clr, integ16_m, ex);
      q16.push_back(ex);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    integ_clr = 1'b0;
    clr_pipe  = 1'b0;
    rst       = 1'b1;
    integ_m   = 0;
    integ16_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t ex;
    r_smp = rst;
    #1;
    if (r_smp) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_u_out", u_out, 0);
      chk("rst_saturated", saturated, 0);
      chk("rst_u_out16", u_out16, 0);
      q.delete();
      q16.delete();
      last_u = 0; last_s = 0; last_u16 = 0; last_s16 = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          ex = q.pop_front();
          chk("u_out", u_out, ex.u);
          chk("saturated", saturated, ex.s);
          last_u = ex.u; last_s = ex.s;
        end
      end else begin
        chk("hold_u_out", u_out, last_u);
        chk("hold_saturated", saturated, last_s);
      end
      if (out_valid16) begin
        if (q16.size() == 0) chk("spurious_valid16", out_valid16, 0);
        else begin
          ex = q16.pop_front();
          chk("u_out16", u_out16, ex.u);
          chk("saturated16", saturated16, ex.s);
          last_u16 = ex.u; last_s16 = ex.s;
        end
      end else begin
        chk("hold_u_out16", u_out16, last_u16);
        chk("hold_saturated16", saturated16, last_s16);
      end
    end
  end

  initial begin
    int sp, fb;
    int waited;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // basic response, then e=0 exposes the integrator (12800 -> 50)
    cycle(1'b1, 100, 0, 1'b0);
    idle(3);
    cycle(1'b1, 0, 0, 1'b0);
    idle(3);

    // windup
    do_reset();
    repeat (4) cycle(1'b1, 100, 0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0);
    idle(3);

    // negative clamp
    do_reset();
    cycle(1'b1, -300, 200, 1'b0);
    idle(3);

    // clear coinciding with stage 2, then e=0
    do_reset();
    cycle(1'b1, 100, 0, 1'b1);
    cycle(1'b1, 0, 0, 1'b0);
    idle(3);

    // reset one cycle after a sample: that sample must vanish
    cycle(1'b1, 50, 0, 1'b0);
    do_reset();
    idle(3);

    // integrator saturation on the 16-bit instance
    repeat (6) cycle(1'b1, 511, 0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0);
    idle(3);

    // randomized phases with fresh gains and limits each phase
    for (int ph = 0; ph < 40; ph++) begin
      @(negedge clk);
      kp      = 10'(int'($urandom_range(1023)) - 512);
      ki      = 10'(int'($urandom_range(1023)) - 512);
      out_min = 10'(int'($urandom_range(1023)) - 512);
      out_max = 10'(int'($urandom_range(1023)) - 512);
      for (int c = 0; c < 30; c++) begin
        sp = int'($urandom_range(1023)) - 512;
        fb = int'($urandom_range(1023)) - 512;
        cycle($urandom_range(9) < 7, sp, fb, $urandom_range(9) == 0);
      end
      idle(3);
    end

    waited = 0;
    while ((q.size() + q16.size()) != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", q.size() + q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
